// File: rtl/de0_cv_system_cpu_mul_seq_if.sv
// rtl/de0_cv_system_cpu_mul_seq_if.sv - request/response bundle for the sequential multiplier
// Signals:
//   start  : request, sampled only while busy=0
//   op     : 00=MUL (low word), 01=MULXUU, 10=MULXSU, 11=MULXSS (high word)
//   src1   : first operand, sampled with start
//   src2   : second operand, sampled with start
//   busy   : high from the cycle after acceptance through the done cycle
//   done   : single-cycle pulse; result is valid in that cycle
//   result : final product word, held until the next done
// Modports: master drives the request, slave is the multiplier.
interface de0_cv_system_cpu_mul_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, src1, src2,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src1, src2,
        output busy, done, result
    );
endinterface

// File: rtl/de0_cv_system_cpu_mul_seq.sv
// rtl/de0_cv_system_cpu_mul_seq.sv - multi-cycle 32x32 multiplier built from one 16x16 unit
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : de0_cv_system_cpu_mul_seq_if.slave (start/op/src1/src2 in, busy/done/result out)
// Sequence: IDLE -> ISSUE (4 cycles) -> DRAIN (1) -> FIX (1) -> IDLE. The FIX cycle is the
// done cycle, so the next request can be accepted on the edge that ends it plus one.
// Optional feature: define DE0_CV_CPU_MUL_EARLY_OUT_EN to let op=00 skip the p3 partial
// product and FIX, finishing in the DRAIN cycle instead.
module de0_cv_system_cpu_mul_seq #(
    parameter int LATENCY = 6
) (
    input  logic                          clk,
    input  logic                          reset_n,
    de0_cv_system_cpu_mul_seq_if.slave    bus
);
    // ISSUE occupies LATENCY-2 cycles; DRAIN and FIX take one each.
    localparam logic [1:0] ISSUE_LAST = 2'(LATENCY - 3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_FIX   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] preg_q, preg_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] result_q, result_d;

    logic        early;
    logic [1:0]  issue_last;
    logic [15:0] mul_x, mul_y;
    logic [31:0] prod;
    logic [63:0] add_sh0, add_sh16, add_sh32;
    logic [31:0] fix_hi;
    logic        done_c;
    logic [31:0] result_c;

`ifdef DE0_CV_CPU_MUL_EARLY_OUT_EN
    assign early = (op_q == 2'b00);
`else
    assign early = 1'b0;
`endif

    assign issue_last = early ? 2'd2 : ISSUE_LAST;

    // cnt[0] picks the high half of a, cnt[1] the high half of b: p0, p1, p2, p3 in order.
    assign mul_x = cnt_q[0] ? a_q[31:16] : a_q[15:0];
    assign mul_y = cnt_q[1] ? b_q[31:16] : b_q[15:0];
    assign prod  = {16'd0, mul_x} * {16'd0, mul_y};

    assign add_sh0  = {32'd0, preg_q};
    assign add_sh16 = {16'd0, preg_q, 16'd0};
    assign add_sh32 = {preg_q, 32'd0};

    // Unsigned high word minus the cross terms that signed interpretation removes.
    assign fix_hi = acc_q[63:32]
                  - ((op_q[1] && a_q[31]) ? b_q : 32'd0)
                  - (((op_q == 2'b11) && b_q[31]) ? a_q : 32'd0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        preg_d   = preg_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_c   = 1'b0;
        result_c = result_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.src1;
                    b_d     = bus.src2;
                    acc_d   = 64'd0;
                    preg_d  = 32'd0;
                    cnt_d   = 2'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                preg_d = prod;
                // preg holds the product issued one cycle earlier (cnt-1).
                if (cnt_q == 2'd1) begin
                    acc_d = acc_q + add_sh0;
                end else if (cnt_q != 2'd0) begin
                    acc_d = acc_q + add_sh16;
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == issue_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Early-out drains p2 (shift 16); the full path drains p3 (shift 32).
                if (early) begin
                    acc_d    = acc_q + add_sh16;
                    done_c   = 1'b1;
                    result_c = acc_d[31:0];
                    result_d = acc_d[31:0];
                    state_d  = S_IDLE;
                end else begin
                    acc_d   = acc_q + add_sh32;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                done_c   = 1'b1;
                result_c = (op_q == 2'b00) ? acc_q[31:0] : fix_hi;
                result_d = result_c;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            op_q     <= 2'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            preg_q   <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            preg_q   <= preg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // The result register captures at the end of the done cycle; during that cycle the
    // freshly computed word is forwarded so it is valid alongside done.
    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = done_c;
    assign bus.result = result_c;
endmodule

// File: doc/de0_cv_system_cpu_mul_seq.md
DE0_CV_SYSTEM_CPU_MUL_SEQ -- requirements
Module: de0_cv_system_cpu_mul_seq

Interface
REQ-001 SHALL provide parameter LATENCY, default 6, meaning clock edges from the accepted start to done; fixed value, not user-tunable.
REQ-002 SHALL provide port clk, input, 1, sole clock; all state changes on the rising edge.
REQ-003 SHALL provide port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port start, input, 1, request; sampled only while busy=0.
REQ-005 SHALL provide port op, input, 2: 00=MUL (low 32), 01=MULXUU, 10=MULXSU (src1 signed, src2 unsigned), 11=MULXSS (high 32 in each MULX case).
REQ-006 SHALL provide ports src1 and src2, input, 32 each, operands; sampled with start.
REQ-007 SHALL provide port busy, output, 1, high from the cycle after the accepted start through the done cycle.
REQ-008 SHALL provide port done, output, 1, single-cycle pulse; result is valid in that cycle.
REQ-009 SHALL provide port result, output, 32, final product word; held until the next done.

Function
REQ-010 Start acceptance: start=1 and busy=0 at an edge latches op, src1 and src2, and enters ISSUE; start while busy=1 is ignored with no queueing.
REQ-011 State machine: IDLE -> ISSUE (4 cycles) -> DRAIN (1) -> FIX (1) -> IDLE.
- done is asserted in the FIX-exit cycle.
- done rises exactly LATENCY edges after the accepting edge.
REQ-012 ISSUE: one 16x16 unsigned multiply per cycle, in the order p0=a[15:0]*b[15:0], p1=a[31:16]*b[15:0], p2=a[15:0]*b[31:16], p3=a[31:16]*b[31:16].
REQ-013 The multiplier output SHALL be registered, 1-cycle latency.
REQ-014 Accumulation into a 64-bit acc (cleared at start):
- p0 at shift 0
- p1 and p2 at shift 16
- p3 at shift 32
- carries propagate the full 64 bits
- unsigned modulo 2^64
REQ-015 FIX applies sign correction to acc[63:32], modulo 2^32:
- subtract src2 if src1 is treated as signed and src1[31]=1;
- subtract src1 if src2 is treated as signed and src2[31]=1.
- src1 is signed for op 10 and 11; src2 is signed for op 11 only.
REQ-016 result SHALL be acc[31:0] for op=00 and corrected acc[63:32] otherwise.
REQ-017 Result register: loads only in the done cycle.
REQ-018 start in the done cycle is ignored, because busy=1 in that cycle; the earliest back-to-back start is the cycle after done.
REQ-019 Operand changes on src1, src2 or op after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-020 reset_n=0 SHALL asynchronously force: state=IDLE, busy=0, done=0, result=0, acc=0, and the multiplier pipeline register=0.
REQ-021 Reset during any state abandons the operation; no done pulse for it.
REQ-022 The first start is accepted on the first edge with reset_n=1.

Configuration
REQ-023 Macro DE0_CV_CPU_MUL_EARLY_OUT_EN controls the op=00 early-out path.
- Defined: op=00 skips p3 and FIX; done comes 4 edges after the accepting edge; MULX ops are unchanged at LATENCY.
- Undefined: all ops take LATENCY=6; op=00 results are bit-identical in both builds.

Verification
REQ-024 MUL, src1=0x00010003, src2=0x00020005 -> result=0x000B000F; done at edge 6, or edge 4 with the macro defined.
REQ-025 MULXUU, 0xFFFFFFFF x 0xFFFFFFFF -> result=0xFFFFFFFE; MULXSS with the same operands -> 0x00000000.
REQ-026 MULXSU, src1=0xFFFFFFFF, src2=0x00000002 -> result=0xFFFFFFFF; MULXSS, 0x80000000 x 0x80000000 -> 0x40000000.
REQ-027 Start pulsed again at edges 2 and 6 of an operation, with different operands -> both ignored; exactly one done with the original result; a start at edge 7 is accepted.
REQ-028 reset_n low at edge 3 of an operation -> busy, done and result are 0 immediately, with no done pulse; after release, MUL 3x5 -> result=0x0000000F.
